acc_control_unit: RTL

Multi-cycle control FSM for the 16-bit accumulator processor. It sits beside the datapath in the top-level connection module. It reads the opcode field of the instruction register plus the accumulator status flags. It drives every write enable and mux select for the PC, IR, memory, accumulator, stack pointer, return-address register and output port, and it stalls on a memory ready handshake.

---
 rtl/acc_isa_pkg.sv | 56 +++++
 rtl/acc_control_unit_if.sv | 40 ++++
 rtl/acc_control_unit.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/acc_isa_pkg.sv
// Shared ISA constants for the 16-bit accumulator processor: opcodes, control
// FSM state encoding and datapath mux/operation encodings.
package acc_isa_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
  localparam logic [OP_W-1:0] OP_AND  = 4'd2;
  localparam logic [OP_W-1:0] OP_OR   = 4'd3;
  localparam logic [OP_W-1:0] OP_LDI  = 4'd4;
  localparam logic [OP_W-1:0] OP_LD   = 4'd5;
  localparam logic [OP_W-1:0] OP_ST   = 4'd6;
  localparam logic [OP_W-1:0] OP_BEQZ = 4'd7;
  localparam logic [OP_W-1:0] OP_BLTZ = 4'd8;
  localparam logic [OP_W-1:0] OP_J    = 4'd9;
  localparam logic [OP_W-1:0] OP_JAL  = 4'd10;
  localparam logic [OP_W-1:0] OP_PUSH = 4'd11;
  localparam logic [OP_W-1:0] OP_POP  = 4'd12;
  localparam logic [OP_W-1:0] OP_IN   = 4'd13;
  localparam logic [OP_W-1:0] OP_OUT  = 4'd14;
  localparam logic [OP_W-1:0] OP_HALT = 4'd15;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_EXEC   = 4'd2,
    ST_MEM_RD = 4'd3,
    ST_MEM_WR = 4'd4,
    ST_BRANCH = 4'd5,
    ST_SP_DEC = 4'd6,
    ST_HALT   = 4'd7
  } state_t;

  localparam logic       PC_SRC_INC  = 1'b0;
  localparam logic       PC_SRC_IMM  = 1'b1;

  localparam logic [1:0] ACC_SRC_ALU = 2'd0;
  localparam logic [1:0] ACC_SRC_IMM = 2'd1;
  localparam logic [1:0] ACC_SRC_MEM = 2'd2;
  localparam logic [1:0] ACC_SRC_IN  = 2'd3;

  localparam logic [1:0] ADDR_PC     = 2'd0;
  localparam logic [1:0] ADDR_IR     = 2'd1;
  localparam logic [1:0] ADDR_SP     = 2'd2;

  localparam logic [1:0] SP_HOLD     = 2'd0;
  localparam logic [1:0] SP_INC      = 2'd1;
  localparam logic [1:0] SP_DEC      = 2'd2;

  // Opcodes 0-3 share their low two bits with the ALU operation select.
  function automatic logic is_alu_op(input logic [OP_W-1:0] op);
    return op[3:2] == 2'b00;
  endfunction

endpackage

// File: rtl/acc_control_unit_if.sv
// Control/status bundle between the accumulator control unit (master) and
// the datapath (slave).
interface acc_control_unit_if;
  import acc_isa_pkg::*;

  logic [OP_W-1:0] opcode;
  logic            acc_zero;
  logic            acc_neg;
  logic            mem_ready;

  logic            ir_write;
  logic            pc_write;
  logic            pc_src;
  logic            mem_read;
  logic            mem_write;
  logic [1:0]      mem_addr_src;
  logic            acc_write;
  logic [1:0]      acc_src;
  logic [1:0]      alu_op;
  logic [1:0]      sp_op;
  logic            ra_write;
  logic            out_write;
  logic            halted;
  logic [3:0]      state_dbg;

  modport master (
    input  opcode, acc_zero, acc_neg, mem_ready,
    output ir_write, pc_write, pc_src, mem_read, mem_write, mem_addr_src,
           acc_write, acc_src, alu_op, sp_op, ra_write, out_write, halted,
           state_dbg
  );

  modport slave (
    output opcode, acc_zero, acc_neg, mem_ready,
    input  ir_write, pc_write, pc_src, mem_read, mem_write, mem_addr_src,
           acc_write, acc_src, alu_op, sp_op, ra_write, out_write, halted,
           state_dbg
  );

endinterface

// File: rtl/acc_control_unit.sv
// Multi-cycle control FSM for the accumulator processor: one state register
// plus next-state and output decode, stalling on the memory ready handshake.
module acc_control_unit
  import acc_isa_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  acc_control_unit_if.master bus
);

  state_t     state_q, state_d;

  logic       ir_write, pc_write, pc_src, mem_read, mem_write;
  logic [1:0] mem_addr_src, acc_src, alu_op, sp_op;
  logic       acc_write, ra_write, out_write, halted;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = PC_SRC_INC;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_addr_src = ADDR_PC;
    acc_write    = 1'b0;
    acc_src      = ACC_SRC_ALU;
    alu_op       = 2'd0;
    sp_op        = SP_HOLD;
    ra_write     = 1'b0;
    out_write    = 1'b0;
    halted       = 1'b0;

    case (state_q)
      ST_FETCH: begin
        mem_read     = 1'b1;
        mem_addr_src = ADDR_PC;
        if (bus.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          pc_src   = PC_SRC_INC;
          state_d  = ST_DECODE;
        end
      end

      ST_DECODE: begin
        case (bus.opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR,
          OP_LD, OP_POP:                 state_d = ST_MEM_RD;
          OP_LDI, OP_IN, OP_OUT:         state_d = ST_EXEC;
          OP_ST:                         state_d = ST_MEM_WR;
          OP_BEQZ, OP_BLTZ, OP_J, OP_JAL: state_d = ST_BRANCH;
          OP_PUSH:                       state_d = ST_SP_DEC;
          OP_HALT:                       state_d = ST_HALT;
          default:                       state_d = ST_FETCH;
        endcase
      end

      ST_EXEC: begin
        state_d = ST_FETCH;
        case (bus.opcode)
          OP_LDI: begin
            acc_write = 1'b1;
            acc_src   = ACC_SRC_IMM;
          end
          OP_IN: begin
            acc_write = 1'b1;
            acc_src   = ACC_SRC_IN;
          end
          OP_OUT:  out_write = 1'b1;
          default: begin
            if (is_alu_op(bus.opcode)) begin
              acc_write = 1'b1;
              acc_src   = ACC_SRC_ALU;
              alu_op    = bus.opcode[1:0];
            end
          end
        endcase
      end

      // Address and request stay fixed for the whole stall; only the
      // completing cycle commits the result.
      ST_MEM_RD: begin
        mem_read     = 1'b1;
        mem_addr_src = (bus.opcode == OP_POP) ? ADDR_SP : ADDR_IR;
        if (is_alu_op(bus.opcode)) alu_op = bus.opcode[1:0];
        if (bus.mem_ready) begin
          acc_write = 1'b1;
          acc_src   = is_alu_op(bus.opcode) ? ACC_SRC_ALU : ACC_SRC_MEM;
          if (bus.opcode == OP_POP) sp_op = SP_INC;
          state_d = ST_FETCH;
        end
      end

      ST_MEM_WR: begin
        mem_write    = 1'b1;
        mem_addr_src = (bus.opcode == OP_PUSH) ? ADDR_SP : ADDR_IR;
        if (bus.mem_ready) state_d = ST_FETCH;
      end

      ST_SP_DEC: begin
        sp_op   = SP_DEC;
        state_d = ST_MEM_WR;
      end

      // The PC was already incremented in FETCH, so JAL saves the return
      // address straight from it.
      ST_BRANCH: begin
        pc_src   = PC_SRC_IMM;
        pc_write = ((bus.opcode == OP_BEQZ) && bus.acc_zero) ||
                   ((bus.opcode == OP_BLTZ) && bus.acc_neg)  ||
                   (bus.opcode == OP_J) || (bus.opcode == OP_JAL);
        ra_write = (bus.opcode == OP_JAL);
        state_d  = ST_FETCH;
      end

      ST_HALT: begin
        halted  = 1'b1;
        state_d = ST_HALT;
      end

      default: state_d = ST_FETCH;
    endcase

    // Reset masks everything, including a handshake completing this cycle.
    if (!reset) begin
      state_d      = ST_FETCH;
      ir_write     = 1'b0;
      pc_write     = 1'b0;
      pc_src       = PC_SRC_INC;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      mem_addr_src = ADDR_PC;
      acc_write    = 1'b0;
      acc_src      = ACC_SRC_ALU;
      alu_op       = 2'd0;
      sp_op        = SP_HOLD;
      ra_write     = 1'b0;
      out_write    = 1'b0;
      halted       = 1'b0;
    end
  end

  assign bus.ir_write     = ir_write;
  assign bus.pc_write     = pc_write;
  assign bus.pc_src       = pc_src;
  assign bus.mem_read     = mem_read;
  assign bus.mem_write    = mem_write;
  assign bus.mem_addr_src = mem_addr_src;
  assign bus.acc_write    = acc_write;
  assign bus.acc_src      = acc_src;
  assign bus.alu_op       = alu_op;
  assign bus.sp_op        = sp_op;
  assign bus.ra_write     = ra_write;
  assign bus.out_write    = out_write;
  assign bus.halted       = halted;
  assign bus.state_dbg    = reset ? state_q : ST_FETCH;

endmodule
